// File: rtl/mult_div_unit.sv
// Multicycle 32-bit multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional macro MULT_DIV_UNSIGNED_EN enables unsigned ops for op codes 10 and 11.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] regA_out,
  input  logic [31:0] regB_out,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] mcand_reg;
  logic [63:0] acc_reg;
  logic [32:0] rem_reg;

  logic        unsigned_op;
`ifdef MULT_DIV_UNSIGNED_EN
  assign unsigned_op = op[1];
`else
  // op[1] carries no meaning in the signed-only build
  assign unsigned_op = op[1] & 1'b0;
`endif

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = ~unsigned_op & regA_out[31];
  assign b_neg = ~unsigned_op & regB_out[31];
  assign a_mag = a_neg ? (~regA_out + 32'd1) : regA_out;
  assign b_mag = b_neg ? (~regB_out + 32'd1) : regB_out;

  // Multiply step: acc = {partial high, remaining multiplier bits}
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, mcand_reg} : 33'd0);
  assign mul_next = {mul_sum, acc_reg[31:1]};

  // Restoring divide step: dividend bits shift out of acc[31:0] as quotient bits shift in
  logic [32:0] div_shift, div_diff, rem_next;
  logic        div_ge;
  logic [31:0] q_next;
  assign div_shift = {rem_reg[31:0], acc_reg[31]};
  assign div_diff  = div_shift - {1'b0, mcand_reg};
  assign div_ge    = ~div_diff[32];
  assign rem_next  = div_ge ? div_diff : div_shift;
  assign q_next    = {acc_reg[30:0], div_ge};

  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign prod_fix = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
  assign quot_fix = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
  assign rem_fix  = neg_r_reg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 5'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      mcand_reg  <= 32'd0;
      acc_reg    <= 64'd0;
      rem_reg    <= 33'd0;
      HI_out     <= 32'd0;
      LO_out     <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            is_div_reg <= op[0];
            cnt_reg    <= 5'd0;
            if (op[0] && (regB_out == 32'd0)) begin
              state_reg <= DONE;
              done      <= 1'b1;
              div_zero  <= 1'b1;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
              mcand_reg <= op[0] ? b_mag : a_mag;
              acc_reg   <= {32'd0, (op[0] ? a_mag : b_mag)};
              rem_reg   <= 33'd0;
              neg_q_reg <= a_neg ^ b_neg;
              neg_r_reg <= op[0] & a_neg;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (is_div_reg) begin
            acc_reg[31:0] <= q_next;
            rem_reg       <= rem_next;
          end else begin
            acc_reg <= mul_next;
          end
          if (cnt_reg == 5'd31) state_reg <= FIX;
        end
        FIX: begin
          if (is_div_reg) begin
            HI_out <= rem_fix;
            LO_out <= quot_fix;
          end else begin
            HI_out <= prod_fix[63:32];
            LO_out <= prod_fix[31:0];
          end
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          div_zero  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO, a monitor checks on done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .regA_out (a),
    .regB_out (b),
    .HI_out   (hi),
    .LO_out   (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, expected no result", hi, lo);
      end else begin
        e = sb.pop_front();
        $display("result hi=%h lo=%h div_zero=%b (want %h %h %b)", hi, lo, div_zero, e.hi, e.lo, e.dz);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int elat, input bit inject);
    int n = 0;
    int bc = 0;
    op = o; a = av; b = bv; start = 1'b1;
    sb.push_back(exp_t'{ehi, elo, edz});
    @(posedge clk);
    #1 start = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0BADF00D; op = ~o;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (inject && n == 10) begin
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
      end
      if (inject && n == 11) start = 1'b0;
      if (busy) bc++;
      if (done) break;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("busy_cycles", 32'(bc), 32'(elat - 1));
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("div_zero_pulse", {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 1'b0);
    run_op(2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0);
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1'b0);
    run_op(2'b01, 32'd5,        32'd2,        32'h00000001, 32'h00000002, 1'b0, 34, 1'b0);
    run_op(2'b01, 32'd9,        32'd0,        32'h00000001, 32'h00000002, 1'b1, 1,  1'b0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 1'b0);
    run_op(2'b00, 32'd3,        32'd5,        32'h00000000, 32'd15,       1'b0, 34, 1'b1);
    run_op(2'b00, 32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0, 34, 1'b0);

    // Reset in the middle of a multiply
    op = 2'b00; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    $display("reset asserted mid-operation");
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd4, 32'h00000000, 32'd12, 1'b0, 34, 1'b0);

`ifdef MULT_DIV_UNSIGNED_EN
    run_op(2'b10, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34, 1'b0);
    run_op(2'b11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'h7FFFFFFF, 1'b0, 34, 1'b0);
`else
    run_op(2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, 1'b0);
    run_op(2'b11, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
